// File: rtl/alu_slice_seq.sv
// Runs 4*NSLICE-bit operations through one combinational 4-bit ALU core, LS slice first,
// chaining carry between slices and merging the per-slice results and flags.
module alu_slice_seq #(
   parameter int NSLICE = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  REQ_VALID,
   output logic                  REQ_READY,
   input  logic [3:0]            REQ_SEL,
   input  logic                  REQ_CI,
   input  logic [4*NSLICE-1:0]   REQ_A,
   input  logic [4*NSLICE-1:0]   REQ_B,
   output logic [3:0]            ALU_SEL,
   output logic                  ALU_CI,
   output logic [3:0]            ALU_A,
   output logic [3:0]            ALU_B,
   input  logic [3:0]            ALU_R,
   input  logic                  ALU_CO,
   input  logic                  ALU_OV,
   input  logic                  ALU_Z,
   input  logic                  ALU_S,
   output logic                  RSP_VALID,
   input  logic                  RSP_READY,
   output logic [4*NSLICE-1:0]   RSP_R,
   output logic                  RSP_CO,
   output logic                  RSP_OV,
   output logic                  RSP_Z,
   output logic                  RSP_S,
   output logic                  BUSY
);

   localparam int W  = 4 * NSLICE;
   localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]    state_reg;
   logic [IW-1:0] idx_reg;
   logic [3:0]    sel_reg;
   logic          ci_reg;
   logic [W-1:0]  a_reg;
   logic [W-1:0]  b_reg;
   logic          carry_reg;
   logic          zacc_reg;
   logic          co_reg;
   logic          ov_reg;
   logic          z_reg;
   logic          s_reg;

   logic [3:0]    a_slice [NSLICE];
   logic [3:0]    b_slice [NSLICE];
   logic [3:0]    r_slice_reg [NSLICE];

   logic          exec;
   logic          last_slice;

   assign exec       = (state_reg == ST_EXEC);
   assign last_slice = (idx_reg == LAST_IDX);

   // Per-slice operand views and result registers; each result slice is
   // written only while the sequencer is on that slice.
   genvar gi;
   generate
      for (gi = 0; gi < NSLICE; gi++) begin : g_slice
         assign a_slice[gi]          = a_reg[4*gi +: 4];
         assign b_slice[gi]          = b_reg[4*gi +: 4];
         assign RSP_R[4*gi +: 4]     = r_slice_reg[gi];

         always_ff @(posedge CLK) begin
            if (RST) begin
               r_slice_reg[gi] <= 4'd0;
            end else if (exec && (idx_reg == IW'(gi))) begin
               r_slice_reg[gi] <= ALU_R;
            end
         end
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg <= ST_IDLE;
         idx_reg   <= '0;
         sel_reg   <= 4'd0;
         ci_reg    <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         carry_reg <= 1'b0;
         zacc_reg  <= 1'b1;
         co_reg    <= 1'b0;
         ov_reg    <= 1'b0;
         z_reg     <= 1'b0;
         s_reg     <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (REQ_VALID) begin
                  sel_reg   <= REQ_SEL;
                  ci_reg    <= REQ_CI;
                  a_reg     <= REQ_A;
                  b_reg     <= REQ_B;
                  idx_reg   <= '0;
                  carry_reg <= 1'b0;
                  zacc_reg  <= 1'b1;
                  state_reg <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               carry_reg <= ALU_CO;
               zacc_reg  <= zacc_reg & ALU_Z;
               if (last_slice) begin
                  co_reg    <= ALU_CO;
                  ov_reg    <= ALU_OV;
                  s_reg     <= ALU_S;
                  z_reg     <= zacc_reg & ALU_Z;
                  idx_reg   <= '0;
                  state_reg <= ST_DONE;
               end else begin
                  idx_reg <= idx_reg + 1'b1;
               end
            end
            ST_DONE: begin
               if (RSP_READY) begin
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Core is combinational: drive it straight from the latched operands.
   assign ALU_SEL = exec ? sel_reg : 4'd0;
   assign ALU_CI  = exec ? ((idx_reg == '0) ? ci_reg : carry_reg) : 1'b0;
   assign ALU_A   = exec ? a_slice[idx_reg] : 4'd0;
   assign ALU_B   = exec ? b_slice[idx_reg] : 4'd0;

   assign REQ_READY = (state_reg == ST_IDLE);
   assign RSP_VALID = (state_reg == ST_DONE);
   assign BUSY      = (state_reg == ST_EXEC) || (state_reg == ST_DONE);
   assign RSP_CO    = co_reg;
   assign RSP_OV    = ov_reg;
   assign RSP_Z     = z_reg;
   assign RSP_S     = s_reg;

endmodule

// File: tb/tb_alu_slice_seq.sv
// Bench for alu_slice_seq: a 4-bit ALU core stand-in, a full-width reference
// model with a per-cycle compare, directed cases and random traffic.
module tb_alu_slice_seq;

   localparam int NSLICE = 2;
   localparam int W = 4 * NSLICE;
   localparam int DONE_PH = NSLICE + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [3:0]    req_sel = 4'd0;
   logic          req_ci = 1'b0;
   logic [W-1:0]  req_a = '0;
   logic [W-1:0]  req_b = '0;
   logic [3:0]    alu_sel;
   logic          alu_ci;
   logic [3:0]    alu_a;
   logic [3:0]    alu_b;
   logic [3:0]    alu_r;
   logic          alu_co;
   logic          alu_ov;
   logic          alu_z;
   logic          alu_s;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [W-1:0]  rsp_r;
   logic          rsp_co;
   logic          rsp_ov;
   logic          rsp_z;
   logic          rsp_s;
   logic          busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_slice_seq #(.NSLICE(NSLICE)) dut (
      .CLK(clk), .RST(rst),
      .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_SEL(req_sel),
      .REQ_CI(req_ci), .REQ_A(req_a), .REQ_B(req_b),
      .ALU_SEL(alu_sel), .ALU_CI(alu_ci), .ALU_A(alu_a), .ALU_B(alu_b),
      .ALU_R(alu_r), .ALU_CO(alu_co), .ALU_OV(alu_ov), .ALU_Z(alu_z), .ALU_S(alu_s),
      .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_R(rsp_r),
      .RSP_CO(rsp_co), .RSP_OV(rsp_ov), .RSP_Z(rsp_z), .RSP_S(rsp_s),
      .BUSY(busy)
   );

   // 4-bit core stand-in: 0 add, 1 subtract (A + ~B + CI), 2 and, 3 or, 4 xor, else pass A
   logic [4:0] core_sum;
   logic       core_ov;
   always_comb begin
      core_sum = 5'd0;
      core_ov  = 1'b0;
      case (alu_sel)
         4'd0: begin
            core_sum = {1'b0, alu_a} + {1'b0, alu_b} + 5'(alu_ci);
            core_ov  = (alu_a[3] == alu_b[3]) && (core_sum[3] != alu_a[3]);
         end
         4'd1: begin
            core_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'(alu_ci);
            core_ov  = (alu_a[3] != alu_b[3]) && (core_sum[3] != alu_a[3]);
         end
         4'd2: core_sum = {1'b0, alu_a & alu_b};
         4'd3: core_sum = {1'b0, alu_a | alu_b};
         4'd4: core_sum = {1'b0, alu_a ^ alu_b};
         default: core_sum = {1'b0, alu_a};
      endcase
   end
   assign alu_r  = core_sum[3:0];
   assign alu_co = core_sum[4];
   assign alu_ov = core_ov;
   assign alu_z  = (core_sum[3:0] == 4'd0);
   assign alu_s  = core_sum[3];

   typedef struct packed {
      logic [W-1:0] r;
      logic         co;
      logic         ov;
      logic         z;
      logic         s;
   } rsp_t;

   // Whole-width result of the operation, as the chained slices must produce it.
   function automatic rsp_t ref_op(logic [3:0] sel, logic ci, logic [W-1:0] a, logic [W-1:0] b);
      rsp_t       res;
      logic [W:0] sum;
      res = '0;
      sum = '0;
      case (sel)
         4'd0: begin
            sum = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
            res.ov = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
         end
         4'd1: begin
            sum = {1'b0, a} + {1'b0, ~b} + (W+1)'(ci);
            res.ov = (a[W-1] != b[W-1]) && (sum[W-1] != a[W-1]);
         end
         4'd2: sum = {1'b0, a & b};
         4'd3: sum = {1'b0, a | b};
         4'd4: sum = {1'b0, a ^ b};
         default: sum = {1'b0, a};
      endcase
      res.r  = sum[W-1:0];
      res.co = sum[W];
      res.z  = (sum[W-1:0] == '0);
      res.s  = sum[W-1];
      return res;
   endfunction

   // Carry into slice k: carry out of the low 4*k bits of the operation.
   function automatic logic ref_ci(logic [3:0] sel, logic ci, logic [W-1:0] a, logic [W-1:0] b, int k);
      logic [W:0] mask;
      logic [W:0] t;
      logic [W-1:0] bb;
      if (k == 0) return ci;
      if (sel != 4'd0 && sel != 4'd1) return 1'b0;
      bb   = (sel == 4'd0) ? b : ~b;
      mask = ((W+1)'(1) << (4 * k)) - (W+1)'(1);
      t    = ({1'b0, a} & mask) + ({1'b0, bb} & mask) + (W+1)'(ci);
      return t[4*k];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 idle, 1..NSLICE executing slice phase-1, NSLICE+1 done.
   int           m_phase = 0;
   logic         m_armed = 1'b0;
   logic [3:0]   m_sel = '0;
   logic         m_ci = 1'b0;
   logic [W-1:0] m_a = '0;
   logic [W-1:0] m_b = '0;
   rsp_t         m_res = '0;
   rsp_t         exp_rsp = '0;
   int           cyc = 0;
   int           last_acc = -1;
   logic         b2b_mode = 1'b0;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_armed = 1'b1;
         m_phase = 0;
         exp_rsp = '0;
      end else if (m_phase == 0) begin
         if (req_valid) begin
            m_sel = req_sel; m_ci = req_ci; m_a = req_a; m_b = req_b;
            m_res = ref_op(req_sel, req_ci, req_a, req_b);
            m_phase = 1;
            if (b2b_mode && last_acc >= 0) chk("b2b_spacing", 32'(cyc - last_acc), 32'(NSLICE + 2));
            last_acc = cyc;
         end
      end else if (m_phase <= NSLICE) begin
         if (m_phase == NSLICE) exp_rsp = m_res;
         m_phase++;
      end else if (rsp_ready) begin
         m_phase = 0;
      end
   end

   always @(negedge clk) begin
      if (m_armed) begin
         chk("req_ready", 32'(req_ready), 32'(m_phase == 0));
         chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == DONE_PH));
         chk("busy", 32'(busy), 32'(m_phase != 0));
         if (m_phase >= 1 && m_phase <= NSLICE) begin
            chk("alu_sel", 32'(alu_sel), 32'(m_sel));
            chk("alu_a", 32'(alu_a), 32'((m_a >> (4 * (m_phase - 1))) & 'hF));
            chk("alu_b", 32'(alu_b), 32'((m_b >> (4 * (m_phase - 1))) & 'hF));
            chk("alu_ci", 32'(alu_ci), 32'(ref_ci(m_sel, m_ci, m_a, m_b, m_phase - 1)));
         end else begin
            chk("alu_idle_zero", {21'd0, alu_sel, alu_ci, alu_a, alu_b}, 32'd0);
            chk("rsp_r", 32'(rsp_r), 32'(exp_rsp.r));
            chk("rsp_flags", {28'd0, rsp_co, rsp_ov, rsp_z, rsp_s},
                {28'd0, exp_rsp.co, exp_rsp.ov, exp_rsp.z, exp_rsp.s});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Issue one request from IDLE and wait for RSP_VALID; leaves the DUT in DONE.
   task automatic start_op(input logic [3:0] sel, input logic ci, input logic [W-1:0] a,
                           input logic [W-1:0] b, output int lat, output logic ci1);
      req_sel = sel; req_ci = ci; req_a = a; req_b = b; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      req_a = W'($urandom); req_b = W'($urandom); req_sel = 4'($urandom); req_ci = 1'($urandom);
      lat = 0;
      ci1 = 1'b0;
      while (!rsp_valid && lat < 20) begin
         if (lat == 1) ci1 = alu_ci;
         tick();
         lat++;
      end
      chk("latency", 32'(lat), 32'(NSLICE));
   endtask

   task automatic release_op();
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   int           lat;
   logic         ci1;
   logic [W-1:0] held_r;

   initial begin
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("reset_req_ready", 32'(req_ready), 32'd1);
      chk("reset_rsp", {23'd0, rsp_valid, rsp_r}, 32'd0);

      // add 0x3C + 0x45: slices 1 then 8 -> 0x81, signed overflow
      start_op(4'd0, 1'b0, 8'h3C, 8'h45, lat, ci1);
      chk("t1_r", 32'(rsp_r), 32'h81);
      chk("t1_flags", {28'd0, rsp_co, rsp_ov, rsp_z, rsp_s}, 32'b0101);
      release_op();

      // 0xFF + 0x01: carry must ripple into slice 1
      start_op(4'd0, 1'b0, 8'hFF, 8'h01, lat, ci1);
      chk("t2_ci_slice1", 32'(ci1), 32'd1);
      chk("t2_r", 32'(rsp_r), 32'h00);
      chk("t2_flags", {28'd0, rsp_co, rsp_ov, rsp_z, rsp_s}, 32'b1010);
      release_op();

      start_op(4'd0, 1'b0, 8'h0F, 8'h0F, lat, ci1);
      chk("t3a_r", 32'(rsp_r), 32'h1E);
      chk("t3a_z", 32'(rsp_z), 32'd0);
      release_op();
      start_op(4'd0, 1'b0, 8'h10, 8'hF0, lat, ci1);
      chk("t3b_r", 32'(rsp_r), 32'h00);
      chk("t3b_z", 32'(rsp_z), 32'd1);
      release_op();

      // Consumer stalls; requests offered meanwhile are ignored
      start_op(4'd1, 1'b1, 8'h5A, 8'h23, lat, ci1);
      held_r = rsp_r;
      chk("t4_r", 32'(rsp_r), 32'h37);
      for (int i = 0; i < 5; i++) begin
         req_valid = 1'($urandom);
         req_a = W'($urandom);
         tick();
         chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
         chk("t4_hold_r", 32'(rsp_r), 32'(held_r));
         chk("t4_req_ready", 32'(req_ready), 32'd0);
      end
      release_op();

      // Reset in the middle of slice 0
      req_sel = 4'd0; req_ci = 1'b0; req_a = 8'h77; req_b = 8'h11; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_req_ready", 32'(req_ready), 32'd1);
      chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("t5_alu_zero", {21'd0, alu_sel, alu_ci, alu_a, alu_b}, 32'd0);
      chk("t5_rsp_r", 32'(rsp_r), 32'd0);
      start_op(4'd0, 1'b0, 8'h12, 8'h34, lat, ci1);
      chk("t5_after_r", 32'(rsp_r), 32'h46);
      release_op();

      // Back-to-back requests with the consumer always ready
      b2b_mode = 1'b1;
      last_acc = -1;
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      for (int i = 0; i < 48; i++) begin
         req_sel = 4'($urandom_range(0, 5));
         req_ci = 1'($urandom);
         req_a = W'($urandom);
         req_b = W'($urandom);
         tick();
      end
      req_valid = 1'b0;
      b2b_mode = 1'b0;
      for (int i = 0; i < 6; i++) tick();

      // Random traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         req_valid = ($urandom_range(0, 2) != 0);
         rsp_ready = ($urandom_range(0, 2) != 0);
         req_sel = 4'($urandom);
         req_ci = 1'($urandom);
         req_a = W'($urandom);
         req_b = W'($urandom);
         rst = ($urandom_range(0, 63) == 0);
         tick();
      end
      rst = 1'b0;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
